// File: rtl/ebc_event_arbiter.sv
// ebc_event_arbiter
// Round-robin arbiter for the event output path of the event-based camera.
// Each accepted arbitration stamps the winning pixel-group ID with the
// wall_clock timestamp sampled in that cycle. It then presents {id, timestamp}
// downstream under a valid/ready handshake.
//
// Parameters:
//   NUM_REQ  number of requesters (2..32)
//   SIZE     timestamp / event counter width
//   ID_W     event ID width
// Ports:
//   clk_i, reset_i    clock, asynchronous active-high reset
//   req_i             level requests, held until granted
//   timestamp_i       wall_clock timestamp, sampled at arbitration
//   gnt_o             one-hot grant, one-cycle pulse per accepted arbitration
//   event_valid_o     event valid
//   event_ready_i     downstream ready
//   event_id_o        index of the granted requester
//   event_ts_o        timestamp captured for the event
//   event_cnt_o       handshaken event count (wraps)
//   busy_o            high while an event is being offered (SEND)
module ebc_event_arbiter #(
  parameter int NUM_REQ = 8,
  parameter int SIZE    = 32,
  parameter int ID_W    = $clog2(NUM_REQ)
) (
  input  logic               clk_i,
  input  logic               reset_i,
  input  logic [NUM_REQ-1:0] req_i,
  input  logic [SIZE-1:0]    timestamp_i,
  output logic [NUM_REQ-1:0] gnt_o,
  output logic               event_valid_o,
  input  logic               event_ready_i,
  output logic [ID_W-1:0]    event_id_o,
  output logic [SIZE-1:0]    event_ts_o,
  output logic [SIZE-1:0]    event_cnt_o,
  output logic               busy_o
);

  typedef enum logic {IDLE, SEND} state_e;

  state_e               state_q, state_d;
  logic [ID_W-1:0]      ptr_q, ptr_d;
  logic [NUM_REQ-1:0]   gnt_q, gnt_d;
  logic                 valid_q, valid_d;
  logic [ID_W-1:0]      id_q, id_d;
  logic [SIZE-1:0]      ts_q, ts_d;
  logic [SIZE-1:0]      cnt_q, cnt_d;

  logic [NUM_REQ-1:0]   arb;
  logic                 win_found;
  logic [ID_W-1:0]      win_id;
  logic [ID_W-1:0]      win_nxt;
  logic                 hs;
  logic                 accept;

  // The requester granted this cycle still has req_i high (it drops one cycle
  // later), so its bit is masked to avoid granting the same event twice.
  assign arb = req_i & ~gnt_q;
  assign hs  = valid_q & event_ready_i;

  // Rotating priority scan: start at ptr_q and wrap through NUM_REQ-1 -> 0.
  always_comb begin
    int idx;
    win_found = 1'b0;
    win_id    = '0;
    idx       = 0;
    for (int i = 0; i < NUM_REQ; i++) begin
      idx = int'(ptr_q) + i;
      if (idx >= NUM_REQ) idx = idx - NUM_REQ;
      if (!win_found && arb[idx[ID_W-1:0]]) begin
        win_found = 1'b1;
        win_id    = idx[ID_W-1:0];
      end
    end
  end

  // NUM_REQ need not be a power of two, so wrap the pointer explicitly.
  assign win_nxt = (win_id == ID_W'(NUM_REQ - 1)) ? '0 : win_id + 1'b1;

  always_comb begin
    state_d = state_q;
    accept  = 1'b0;
    cnt_d   = cnt_q;
    case (state_q)
      IDLE: begin
        if (win_found) begin
          accept  = 1'b1;
          state_d = SEND;
        end
      end
      SEND: begin
        // No re-arbitration while stalled; the pending event holds.
        if (hs) begin
          cnt_d = cnt_q + SIZE'(1);
          if (win_found) accept  = 1'b1;
          else           state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    ptr_d   = ptr_q;
    id_d    = id_q;
    ts_d    = ts_q;
    gnt_d   = '0;
    valid_d = (state_d == SEND);
    if (accept) begin
      ptr_d = win_nxt;
      id_d  = win_id;
      ts_d  = timestamp_i;   // raw capture; wall_clock wraps pass through
      gnt_d = NUM_REQ'(1) << win_id;
    end
  end

  always_ff @(posedge clk_i or posedge reset_i) begin
    if (reset_i) begin
      state_q <= IDLE;
      ptr_q   <= '0;
      gnt_q   <= '0;
      valid_q <= 1'b0;
      id_q    <= '0;
      ts_q    <= '0;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      ptr_q   <= ptr_d;
      gnt_q   <= gnt_d;
      valid_q <= valid_d;
      id_q    <= id_d;
      ts_q    <= ts_d;
      cnt_q   <= cnt_d;
    end
  end

  assign gnt_o         = gnt_q;
  assign event_valid_o = valid_q;
  assign event_id_o    = id_q;
  assign event_ts_o    = ts_q;
  assign event_cnt_o   = cnt_q;
  assign busy_o        = (state_q == SEND);

endmodule

// File: tb/tb_ebc_event_arbiter.sv
// Directed bench for ebc_event_arbiter (NUM_REQ=8, SIZE=32).
// Inputs are changed 1ns after each rising edge; outputs are checked at the
// same point, so each check sees the registers loaded at the preceding edge.
module tb_ebc_event_arbiter;
  localparam int N = 8;
  localparam int S = 32;

  logic         clk = 1'b0;
  logic         reset;
  logic [N-1:0] req;
  logic [S-1:0] ts;
  logic         ready;
  logic [N-1:0] gnt_o;
  logic         event_valid_o;
  logic [2:0]   event_id_o;
  logic [S-1:0] event_ts_o;
  logic [S-1:0] event_cnt_o;
  logic         busy_o;

  int pass_cnt = 0;
  int total    = 0;

  ebc_event_arbiter #(.NUM_REQ(N), .SIZE(S)) dut (
    .clk_i(clk), .reset_i(reset), .req_i(req), .timestamp_i(ts),
    .gnt_o(gnt_o), .event_valid_o(event_valid_o), .event_ready_i(ready),
    .event_id_o(event_id_o), .event_ts_o(event_ts_o),
    .event_cnt_o(event_cnt_o), .busy_o(busy_o)
  );

  always #5 clk = ~clk;

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset;
    reset = 1'b1; req = '0; ready = 1'b0;
    tick();
    reset = 1'b0;
  endtask

  task automatic test_reset;
    reset = 1'b1; req = '0; ready = 1'b0; ts = '0;
    #1;
    total++; if (gnt_o !== 8'h00) $display("FAIL reset_gnt got %h want 00", gnt_o); else pass_cnt++;
    total++; if (event_valid_o !== 1'b0) $display("FAIL reset_valid got %b want 0", event_valid_o); else pass_cnt++;
    total++; if (event_id_o !== 3'd0) $display("FAIL reset_id got %0d want 0", event_id_o); else pass_cnt++;
    total++; if (event_ts_o !== 32'd0) $display("FAIL reset_ts got %h want 0", event_ts_o); else pass_cnt++;
    total++; if (event_cnt_o !== 32'd0) $display("FAIL reset_cnt got %0d want 0", event_cnt_o); else pass_cnt++;
    total++; if (busy_o !== 1'b0) $display("FAIL reset_busy got %b want 0", busy_o); else pass_cnt++;
    tick(); tick();
    reset = 1'b0; ready = 1'b1;
    tick(); tick();
    // ready high with nothing valid must not count anything
    total++; if (event_cnt_o !== 32'd0) $display("FAIL idle_ready_cnt got %0d want 0", event_cnt_o); else pass_cnt++;
    total++; if (event_valid_o !== 1'b0) $display("FAIL idle_valid got %b want 0", event_valid_o); else pass_cnt++;
  endtask

  task automatic test_single;
    req = 8'h04; ts = 32'd100; ready = 1'b1;
    tick();
    total++; if (gnt_o !== 8'h04) $display("FAIL single_gnt got %h want 04", gnt_o); else pass_cnt++;
    total++; if (event_id_o !== 3'd2) $display("FAIL single_id got %0d want 2", event_id_o); else pass_cnt++;
    total++; if (event_ts_o !== 32'd100) $display("FAIL single_ts got %0d want 100", event_ts_o); else pass_cnt++;
    total++; if (event_valid_o !== 1'b1) $display("FAIL single_valid got %b want 1", event_valid_o); else pass_cnt++;
    total++; if (busy_o !== 1'b1) $display("FAIL single_busy got %b want 1", busy_o); else pass_cnt++;
    tick();
    req = 8'h00;
    total++; if (event_cnt_o !== 32'd1) $display("FAIL single_cnt got %0d want 1", event_cnt_o); else pass_cnt++;
    total++; if (event_valid_o !== 1'b0) $display("FAIL single_idle_valid got %b want 0", event_valid_o); else pass_cnt++;
    total++; if (busy_o !== 1'b0) $display("FAIL single_idle_busy got %b want 0", busy_o); else pass_cnt++;
    total++; if (gnt_o !== 8'h00) $display("FAIL single_idle_gnt got %h want 00", gnt_o); else pass_cnt++;
  endtask

  task automatic test_all_req;
    logic [N-1:0] exp_g;
    do_reset();
    ready = 1'b1; req = 8'hFF; ts = 32'd200;
    for (int k = 0; k < 8; k++) begin
      tick();
      exp_g = 8'h01 << k;
      total++; if (gnt_o !== exp_g) $display("FAIL all_gnt%0d got %h want %h", k, gnt_o, exp_g); else pass_cnt++;
      total++; if (event_id_o !== 3'(k)) $display("FAIL all_id%0d got %0d want %0d", k, event_id_o, k); else pass_cnt++;
      total++; if (event_ts_o !== 32'(200 + k)) $display("FAIL all_ts%0d got %0d want %0d", k, event_ts_o, 200 + k); else pass_cnt++;
      total++; if (event_valid_o !== 1'b1) $display("FAIL all_valid%0d got %b want 1", k, event_valid_o); else pass_cnt++;
      // requesters granted before this cycle have dropped; this one drops next cycle
      req = 8'hFF << k;
      ts  = 32'(201 + k);
    end
    tick();
    req = 8'h00;
    total++; if (event_cnt_o !== 32'd8) $display("FAIL all_cnt got %0d want 8", event_cnt_o); else pass_cnt++;
    total++; if (event_valid_o !== 1'b0) $display("FAIL all_end_valid got %b want 0", event_valid_o); else pass_cnt++;
  endtask

  task automatic test_fairness;
    logic [2:0] exp_id [4];
    logic [2:0] prev;
    exp_id = '{3'd1, 3'd5, 3'd1, 3'd5};
    prev = 3'd7;
    do_reset();
    ready = 1'b1; req = 8'h22; ts = 32'd10;
    for (int k = 0; k < 4; k++) begin
      tick();
      total++; if (event_id_o !== exp_id[k]) $display("FAIL rr_id%0d got %0d want %0d", k, event_id_o, exp_id[k]); else pass_cnt++;
      total++; if (gnt_o !== (8'h01 << exp_id[k])) $display("FAIL rr_gnt%0d got %h want %h", k, gnt_o, 8'h01 << exp_id[k]); else pass_cnt++;
      total++; if (event_id_o === prev) $display("FAIL rr_repeat%0d got %0d want not %0d", k, event_id_o, prev); else pass_cnt++;
      prev = event_id_o;
    end
    req = 8'h00;
    tick();
    total++; if (event_cnt_o !== 32'd4) $display("FAIL rr_cnt got %0d want 4", event_cnt_o); else pass_cnt++;
  endtask

  task automatic test_backpressure;
    logic [S-1:0] hs_ts;
    do_reset();
    ready = 1'b0; req = 8'h02; ts = 32'd300;
    tick();
    total++; if (gnt_o !== 8'h02) $display("FAIL bp_first_gnt got %h want 02", gnt_o); else pass_cnt++;
    req = 8'h0A; ts = 32'd301;
    for (int c = 0; c < 5; c++) begin
      tick();
      total++; if (event_id_o !== 3'd1) $display("FAIL bp_id%0d got %0d want 1", c, event_id_o); else pass_cnt++;
      total++; if (event_ts_o !== 32'd300) $display("FAIL bp_ts%0d got %0d want 300", c, event_ts_o); else pass_cnt++;
      total++; if (gnt_o !== 8'h00) $display("FAIL bp_gnt%0d got %h want 00", c, gnt_o); else pass_cnt++;
      total++; if (busy_o !== 1'b1) $display("FAIL bp_busy%0d got %b want 1", c, busy_o); else pass_cnt++;
      total++; if (event_valid_o !== 1'b1) $display("FAIL bp_valid%0d got %b want 1", c, event_valid_o); else pass_cnt++;
      req = 8'h08;
      ts  = 32'(302 + c);
    end
    ready = 1'b1;
    hs_ts = ts;
    tick();
    total++; if (gnt_o !== 8'h08) $display("FAIL bp_gnt3 got %h want 08", gnt_o); else pass_cnt++;
    total++; if (event_id_o !== 3'd3) $display("FAIL bp_id3 got %0d want 3", event_id_o); else pass_cnt++;
    total++; if (event_ts_o !== hs_ts) $display("FAIL bp_ts3 got %0d want %0d", event_ts_o, hs_ts); else pass_cnt++;
    tick();
    req = 8'h00;
    total++; if (event_cnt_o !== 32'd2) $display("FAIL bp_cnt got %0d want 2", event_cnt_o); else pass_cnt++;
    total++; if (busy_o !== 1'b0) $display("FAIL bp_end_busy got %b want 0", busy_o); else pass_cnt++;
  endtask

  task automatic test_reset_mid;
    do_reset();
    ready = 1'b0; req = 8'h08; ts = 32'd400;
    tick();   // id 3 in flight, pointer now 4
    #2 reset = 1'b1;
    #1;
    total++; if (event_valid_o !== 1'b0) $display("FAIL rst_mid_valid got %b want 0", event_valid_o); else pass_cnt++;
    total++; if (busy_o !== 1'b0) $display("FAIL rst_mid_busy got %b want 0", busy_o); else pass_cnt++;
    total++; if (event_id_o !== 3'd0) $display("FAIL rst_mid_id got %0d want 0", event_id_o); else pass_cnt++;
    total++; if (event_ts_o !== 32'd0) $display("FAIL rst_mid_ts got %h want 0", event_ts_o); else pass_cnt++;
    req = 8'h81; ts = 32'd450;
    tick();
    reset = 1'b0;
    tick();
    // pointer restarted at 0, so 0 wins over 7
    total++; if (event_id_o !== 3'd0) $display("FAIL rst_ptr_id got %0d want 0", event_id_o); else pass_cnt++;
    total++; if (event_ts_o !== 32'd450) $display("FAIL rst_ptr_ts got %0d want 450", event_ts_o); else pass_cnt++;
    #2 reset = 1'b1;
    #1;
    total++; if (gnt_o !== 8'h00) $display("FAIL rst_mid2_gnt got %h want 00", gnt_o); else pass_cnt++;
    req = 8'h80; ts = 32'd500;
    tick();
    reset = 1'b0;
    tick();
    total++; if (gnt_o !== 8'h80) $display("FAIL rst_gnt7 got %h want 80", gnt_o); else pass_cnt++;
    total++; if (event_id_o !== 3'd7) $display("FAIL rst_id7 got %0d want 7", event_id_o); else pass_cnt++;
    total++; if (event_ts_o !== 32'd500) $display("FAIL rst_ts7 got %0d want 500", event_ts_o); else pass_cnt++;
    total++; if (event_cnt_o !== 32'd0) $display("FAIL rst_cnt got %0d want 0", event_cnt_o); else pass_cnt++;
  endtask

  task automatic test_ts_wrap;
    do_reset();
    ready = 1'b1; req = 8'h01; ts = 32'hFFFF_FFFF;
    tick();
    total++; if (event_ts_o !== 32'hFFFF_FFFF) $display("FAIL wrap_ts0 got %h want ffffffff", event_ts_o); else pass_cnt++;
    req = 8'h03; ts = 32'h0000_0000;
    tick();
    total++; if (event_ts_o !== 32'h0000_0000) $display("FAIL wrap_ts1 got %h want 00000000", event_ts_o); else pass_cnt++;
    total++; if (event_id_o !== 3'd1) $display("FAIL wrap_id1 got %0d want 1", event_id_o); else pass_cnt++;
    req = 8'h02;
    tick();
    req = 8'h00;
    total++; if (event_cnt_o !== 32'd2) $display("FAIL wrap_cnt got %0d want 2", event_cnt_o); else pass_cnt++;
  endtask

  initial begin
    test_reset();
    test_single();
    test_all_req();
    test_fairness();
    test_backpressure();
    test_reset_mid();
    test_ts_wrap();
    $display("%0d/%0d checks passed", pass_cnt, total);
    $finish;
  end

endmodule
